// File: rtl/key_encoder_pkg.sv
// Shared types and constants for the debounced push-button priority encoder.
package key_encoder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    HELD,
    RELEASE
  } ke_state_t;

  localparam int HIST_W = 32;

endpackage

// File: rtl/key_encoder_prienc.sv
// Combinational priority encoder: highest set index of s, 0 when nothing is set.
module prienc #(
  parameter int N      = 20,
  parameter int CODE_W = 5
) (
  input  logic [N-1:0]      s,
  output logic [CODE_W-1:0] pc,
  output logic              any
);

  // Ascending scan so the last (highest) set bit overrides lower ones.
  always_comb begin
    pc = '0;
    for (int i = 0; i < N; i++) begin
      if (s[i]) pc = CODE_W'(i);
    end
  end

  assign any = |s;

endmodule

// File: rtl/key_encoder.sv
// Debounced priority encoder for the push-button bank with registered code/valid/strobe.
// Optional hex-digit history register is enabled by defining KEY_ENCODER_HISTORY_EN.
module key_encoder
  import key_encoder_pkg::*;
#(
  parameter int N         = 20,
  parameter int CODE_W    = 5,
  parameter int DB_CYCLES = 2
) (
  input  logic              hz100,
  input  logic              reset,
  input  logic [N-1:0]      pb,
  output logic [CODE_W-1:0] code,
  output logic              valid,
  output logic              strobe,
  output logic [HIST_W-1:0] hist
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [N-1:0]      sync_a;
  logic [N-1:0]      s;
  logic [CODE_W-1:0] pc;
  logic              any;

  ke_state_t         state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [CODE_W-1:0] cand, cand_next;
  logic [CODE_W-1:0] code_next;
  logic              valid_next;
  logic              strobe_next;

  always_ff @(posedge hz100) begin
    if (reset) begin
      sync_a <= '0;
      s      <= '0;
    end else begin
      sync_a <= pb;
      s      <= sync_a;
    end
  end

  prienc #(
    .N     (N),
    .CODE_W(CODE_W)
  ) u_prienc (
    .s  (s),
    .pc (pc),
    .any(any)
  );

  always_ff @(posedge hz100) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      cand   <= '0;
      code   <= '0;
      valid  <= 1'b0;
      strobe <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      cand   <= cand_next;
      code   <= code_next;
      valid  <= valid_next;
      strobe <= strobe_next;
    end
  end

  // Strobe defaults low so it can only ever be a single-cycle pulse on DEBOUNCE->HELD.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    cand_next   = cand;
    code_next   = code;
    valid_next  = valid;
    strobe_next = 1'b0;
    case (state)
      IDLE: begin
        if (any) begin
          state_next = DEBOUNCE;
          cand_next  = pc;
          cnt_next   = '0;
        end
      end
      DEBOUNCE: begin
        if (!any || (pc != cand)) begin
          state_next = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_next  = HELD;
          code_next   = cand;
          valid_next  = 1'b1;
          strobe_next = 1'b1;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      HELD: begin
        if (!any) begin
          state_next = RELEASE;
          cnt_next   = '0;
        end
      end
      RELEASE: begin
        if (any) begin
          state_next = HELD;
        end else if (cnt == CNT_LAST) begin
          state_next = IDLE;
          valid_next = 1'b0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef KEY_ENCODER_HISTORY_EN
  logic [HIST_W-1:0] hist_q;
  logic [31:0]       code_ext;

  assign code_ext = 32'(code);

  // Only codes that fit a hex digit are recorded; larger keys leave the history untouched.
  always_ff @(posedge hz100) begin
    if (reset) begin
      hist_q <= '0;
    end else if (strobe && (code_ext < 32'd16)) begin
      hist_q <= {hist_q[HIST_W-5:0], code_ext[3:0]};
    end
  end

  assign hist = hist_q;
`else
  assign hist = '0;
`endif

endmodule

// File: tb/tb_key_encoder.sv
// Scoreboard testbench for key_encoder: expected codes are queued per press and
// popped whenever the DUT strobes. Define KEY_ENCODER_HISTORY_EN to check the history.
module tb_key_encoder;

  localparam int N         = 20;
  localparam int CODE_W    = 5;
  localparam int DB_CYCLES = 2;

  logic              hz100 = 1'b0;
  logic              reset;
  logic [N-1:0]      pb;
  logic [CODE_W-1:0] code;
  logic              valid;
  logic              strobe;
  logic [31:0]       hist;

  int assert_count = 0;
  int fail_count   = 0;
  int strobe_count = 0;
  int push_count   = 0;
  int exp_q[$];
  int sb_exp;
  logic prev_strobe = 1'b0;

  key_encoder #(
    .N        (N),
    .CODE_W   (CODE_W),
    .DB_CYCLES(DB_CYCLES)
  ) dut (
    .hz100 (hz100),
    .reset (reset),
    .pb    (pb),
    .code  (code),
    .valid (valid),
    .strobe(strobe),
    .hist  (hist)
  );

  always #5 hz100 = ~hz100;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [N-1:0] key_bit(input int k);
    logic [N-1:0] v;
    v    = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  task automatic waitEdges(input int n);
    repeat (n) @(negedge hz100);
  endtask

  task automatic applyStimulus(input logic [N-1:0] pattern);
    pb = pattern;
  endtask

  task automatic expectPress(input int k);
    exp_q.push_back(k);
    push_count++;
  endtask

  // Full press/hold/release of one key; expects exactly one strobe carrying k.
  task automatic pressKey(input int k);
    applyStimulus(key_bit(k));
    expectPress(k);
    waitEdges(6);
    checkOutput("press_code", 32'(code), 32'(k));
    checkOutput("press_valid", 32'(valid), 32'd1);
    applyStimulus('0);
    waitEdges(6);
    checkOutput("press_released", 32'(valid), 32'd0);
  endtask

  // Scoreboard: every strobe must match the oldest outstanding press.
  always @(negedge hz100) begin
    if (!reset && strobe) begin
      strobe_count++;
      checkOutput("strobe_not_consecutive", 32'(prev_strobe), 32'd0);
      checkOutput("sb_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        sb_exp = exp_q.pop_front();
        checkOutput("sb_code", 32'(code), 32'(sb_exp));
        checkOutput("sb_valid", 32'(valid), 32'd1);
      end
    end
    prev_strobe = strobe;
  end

  initial begin
    reset = 1'b1;
    pb    = '0;
    waitEdges(3);
    checkOutput("reset_code", 32'(code), 32'd0);
    checkOutput("reset_valid", 32'(valid), 32'd0);
    checkOutput("reset_strobe", 32'(strobe), 32'd0);
    checkOutput("reset_hist", hist, 32'd0);
    reset = 1'b0;
    waitEdges(2);

    // Single key: strobe exactly at edge t+4, valid falls 4 edges after release sampled.
    applyStimulus(key_bit(5));
    expectPress(5);
    waitEdges(4);
    checkOutput("t1_pre_strobe", 32'(strobe), 32'd0);
    checkOutput("t1_pre_valid", 32'(valid), 32'd0);
    waitEdges(1);
    checkOutput("t1_strobe_edge4", 32'(strobe), 32'd1);
    checkOutput("t1_code", 32'(code), 32'd5);
    waitEdges(1);
    checkOutput("t1_strobe_one_cycle", 32'(strobe), 32'd0);
    checkOutput("t1_valid_held", 32'(valid), 32'd1);
    waitEdges(4);
    applyStimulus('0);
    waitEdges(4);
    checkOutput("t1_valid_before_fall", 32'(valid), 32'd1);
    waitEdges(1);
    checkOutput("t1_valid_fall", 32'(valid), 32'd0);
    checkOutput("t1_code_holds", 32'(code), 32'd5);
    waitEdges(3);

    // Simultaneous keys: highest wins; a later higher key while held is ignored.
    applyStimulus(key_bit(3) | key_bit(17));
    expectPress(17);
    waitEdges(6);
    checkOutput("t2_code_17", 32'(code), 32'd17);
    checkOutput("t2_valid", 32'(valid), 32'd1);
    applyStimulus(pb | key_bit(19));
    waitEdges(6);
    checkOutput("t2_code_stays_17", 32'(code), 32'd17);
    applyStimulus('0);
    waitEdges(6);
    checkOutput("t2_released", 32'(valid), 32'd0);

    // Press bounce 1-0-1-0 then stable: one strobe, only after the stable run.
    expectPress(7);
    for (int i = 0; i < 4; i++) begin
      applyStimulus((i % 2 == 0) ? key_bit(7) : '0);
      waitEdges(1);
    end
    applyStimulus(key_bit(7));
    waitEdges(4);
    checkOutput("t3_no_early_strobe", 32'(strobe), 32'd0);
    waitEdges(1);
    checkOutput("t3_strobe", 32'(strobe), 32'd1);
    checkOutput("t3_code", 32'(code), 32'd7);
    waitEdges(3);
    applyStimulus('0);
    waitEdges(6);

    // Release bounce: valid must stay high, no second strobe.
    applyStimulus(key_bit(9));
    expectPress(9);
    waitEdges(8);
    applyStimulus('0);
    waitEdges(1);
    applyStimulus(key_bit(9));
    for (int i = 0; i < 8; i++) begin
      waitEdges(1);
      checkOutput("t4_valid_through_bounce", 32'(valid), 32'd1);
    end
    applyStimulus('0);
    waitEdges(6);
    checkOutput("t4_released", 32'(valid), 32'd0);
    checkOutput("t4_code_holds", 32'(code), 32'd9);

    // Reset while debouncing abandons the press.
    applyStimulus(key_bit(12));
    waitEdges(3);
    reset = 1'b1;
    applyStimulus('0);
    waitEdges(1);
    checkOutput("t5_code_cleared", 32'(code), 32'd0);
    checkOutput("t5_valid_cleared", 32'(valid), 32'd0);
    checkOutput("t5_strobe_cleared", 32'(strobe), 32'd0);
    checkOutput("t5_hist_cleared", hist, 32'd0);
    reset = 1'b0;
    waitEdges(10);
    checkOutput("t5_no_accept", 32'(valid), 32'd0);

    // History sequence; code 18 is accepted but not recorded.
    pressKey(1);
    pressKey(2);
    pressKey(10);
    pressKey(18);
    pressKey(3);
`ifdef KEY_ENCODER_HISTORY_EN
    checkOutput("t6_hist", hist, 32'h0000_12A3);
`else
    checkOutput("t6_hist_tied", hist, 32'd0);
`endif

    // Extreme indices.
    pressKey(N - 1);
    pressKey(0);

    waitEdges(2);
    checkOutput("sb_drained", 32'(exp_q.size()), 32'd0);
    checkOutput("strobe_total", 32'(strobe_count), 32'(push_count));

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/key_encoder.md
# key_encoder

Debounced priority encoder for the push-button bank: the inverse of the board's 3-to-8 decode path. Synchronizes `pb`, selects the highest-numbered pressed button, debounces it over a programmable number of clock cycles and emits a registered binary code with a one-cycle `strobe` per accepted press. Sits between the raw `pb` inputs and any digit-entry, display or FSM logic in `top`.

## Interface
- `N`, 20: number of button inputs, 2..32.
- `CODE_W`, 5: code width, must satisfy 2**CODE_W >= N.
- `DB_CYCLES`, 2: consecutive stable cycles required to accept a press or release, >= 1.

- `hz100`  in  1  clock; one clock, all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `pb`  in  N  raw, asynchronous button levels, 1 = pressed.
- `code`  out  CODE_W  index of the accepted button; holds its value after release.
- `valid`  out  1  high while an accepted button is held, including release debounce.
- `strobe`  out  1  one-cycle pulse on each accepted press.
- `hist`  out  32  last eight hex digits entered (see Configuration).

## Operation
- Two-flop synchronizer, `pb` to `s`. Priority encode `s`: `any = |s`; `pc` = highest set index, 0 if none.
- FSM states: IDLE, DEBOUNCE, HELD, RELEASE. Counter `cnt`, width $clog2(DB_CYCLES+1).
- IDLE: if `any`, go to DEBOUNCE; latch `cand = pc`; set `cnt = 0`.
- DEBOUNCE: if `!any` or `pc != cand`, go to IDLE. Else if `cnt == DB_CYCLES-1`, go to HELD and register `code = cand`, `valid = 1`, `strobe = 1`. Otherwise `cnt++`.
- HELD: `strobe = 0`. If `!any`, go to RELEASE with `cnt = 0`. Changes in the pressed set while held are ignored: no re-strobe until a full release.
- RELEASE: if `any`, return to HELD with no strobe (bounce). Else if `cnt == DB_CYCLES-1`, go to IDLE with `valid = 0`. Otherwise `cnt++`.
- Simultaneous presses: the highest index wins. A higher key arriving during DEBOUNCE restarts the sequence via IDLE.
- Reset values: synchronizer 0, state IDLE, `cnt` 0, `code` 0, `valid` 0, `strobe` 0, `hist` 0. Reset mid-operation abandons any press in progress; no strobe is issued for it.

## Timing
- Press first sampled at edge t: DEBOUNCE is entered at edge t+2. `strobe`, `valid` and `code` update at edge t+2+DB_CYCLES. With the default DB_CYCLES = 2, this is edge t+4.
- `strobe` is high for exactly one cycle per accepted press and is never high in consecutive cycles.
- Release first sampled at edge r: RELEASE at r+2; `valid` falls at r+2+DB_CYCLES.
- All outputs are registered; there are no combinational paths from `pb` to outputs.

## Configuration
- `KEY_ENCODER_HISTORY_EN` defined: `hist` is a 32-bit shift register. On `strobe` with `code < 16`, `hist <= {hist[27:0], code[3:0]}`. Codes of 16 and above do not shift.
- Macro undefined: `hist` is tied to 0 and no history flops are built.

## Structure
- `key_encoder_pkg`: FSM state enum `ke_state_t` (IDLE, DEBOUNCE, HELD, RELEASE) and constant `HIST_W = 32`.
- One combinational sub-module, `prienc`, parameterized on `N` and `CODE_W`, producing `pc` and `any`. FSM, counter, synchronizer and history register live in `key_encoder`.

## Test plan
- `pb[5]` held for 10 cycles from edge 0, DB_CYCLES = 2: `strobe` pulses once at edge 4 with `code = 5`, `valid = 1`. After release, `valid = 0` DB_CYCLES+2 edges later and `code` stays at 5.
- `pb[3]` and `pb[17]` pressed together: `code = 17`, one strobe. Add `pb[19]` while held: no new strobe, `code` stays at 17.
- `pb[7]` bounces 1-0-1 with 1-cycle gaps, then stays stable: exactly one strobe, `code = 7`, issued only after DB_CYCLES stable cycles.
- Release bounce on a held key (0 for 1 cycle, then 1 again): `valid` stays high and no second strobe occurs.
- `reset` asserted for one cycle during DEBOUNCE: all outputs are 0 the next cycle and no strobe is issued for that press.
- With `KEY_ENCODER_HISTORY_EN`, press sequence 1, 2, 10, 18, 3: `hist = 32'h0000_12A3`.
